// File: rtl/perf_counter_bank.sv
// Bank of multi-bit-increment event counters with sticky overflow, a snapshot
// shadow bank and a one-cycle registered read port.
module perf_counter_bank #(
    parameter int NUM_CNT   = 9,
    parameter int CNT_WIDTH = 64,
    parameter int INC_WIDTH = 1,
    parameter int SATURATE  = 0,
    parameter int ADDR_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CNT*INC_WIDTH-1:0] event_inc,
    input  logic                         cnt_en,
    input  logic                         clear,
    input  logic                         snap,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_shadow,
    output logic                         rd_ack,
    output logic [CNT_WIDTH-1:0]         rd_data,
    output logic                         rd_ovf,
    output logic [NUM_CNT-1:0]           ovf
);

    logic [CNT_WIDTH-1:0] r_cnt    [NUM_CNT];
    logic [CNT_WIDTH-1:0] r_sh_cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   r_ovf;
    logic [NUM_CNT-1:0]   r_sh_ovf;
    logic                 r_rd_ack;
    logic [CNT_WIDTH-1:0] r_rd_data;
    logic                 r_rd_ovf;

    logic [CNT_WIDTH:0]   w_sum     [NUM_CNT];
    logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_CNT];
    logic [NUM_CNT-1:0]   w_ovf_nxt;
    logic [CNT_WIDTH-1:0] w_rd_data;
    logic                 w_rd_ovf;

    // Next-state of every live counter: clear wins over counting, carry-out sets the sticky flag.
    always_comb begin
        w_ovf_nxt = r_ovf;
        for (int i = 0; i < NUM_CNT; i++) begin
            w_sum[i]     = {1'b0, r_cnt[i]} + (CNT_WIDTH+1)'(event_inc[i*INC_WIDTH +: INC_WIDTH]);
            w_cnt_nxt[i] = r_cnt[i];
            if (clear) begin
                w_cnt_nxt[i] = '0;
                w_ovf_nxt[i] = 1'b0;
            end else if (cnt_en) begin
                if (w_sum[i][CNT_WIDTH]) begin
                    w_ovf_nxt[i] = 1'b1;
                    if (SATURATE != 0) begin
                        w_cnt_nxt[i] = '1;
                    end else begin
                        w_cnt_nxt[i] = w_sum[i][CNT_WIDTH-1:0];
                    end
                end else begin
                    w_cnt_nxt[i] = w_sum[i][CNT_WIDTH-1:0];
                end
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Read mux over current register values; unmapped addresses return zero.
    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        if (int'(rd_addr) < NUM_CNT) begin
            if (rd_shadow) begin
                w_rd_data = r_sh_cnt[rd_addr];
                w_rd_ovf  = r_sh_ovf[rd_addr];
            end else begin
                w_rd_data = r_cnt[rd_addr];
                w_rd_ovf  = r_ovf[rd_addr];
            end
        end else begin
            w_rd_data = '0;
            w_rd_ovf  = 1'b0;
        end
    end

    // Live counters and shadow bank; the shadow samples pre-update values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_cnt[i]    <= '0;
                r_sh_cnt[i] <= '0;
            end
            r_ovf    <= '0;
            r_sh_ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (snap) begin
                    r_sh_cnt[i] <= r_cnt[i];
                end else begin
                    r_sh_cnt[i] <= r_sh_cnt[i];
                end
            end
            r_ovf <= w_ovf_nxt;
            if (snap) begin
                r_sh_ovf <= r_ovf;
            end else begin
                r_sh_ovf <= r_sh_ovf;
            end
        end
    end

    // Registered read port; data holds between acks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            r_rd_ack <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_data;
                r_rd_ovf  <= w_rd_ovf;
            end else begin
                r_rd_data <= r_rd_data;
                r_rd_ovf  <= r_rd_ovf;
            end
        end
    end

    assign rd_ack  = r_rd_ack;
    assign rd_data = r_rd_data;
    assign rd_ovf  = r_rd_ovf;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a wrap-mode and a saturate-mode bank driven in lockstep,
// read results checked against a queue of expected values.
module tb_perf_counter_bank;

    localparam int NC = 3;
    localparam int CW = 8;
    localparam int IW = 3;

    logic            clock;
    logic            reset;
    logic [NC*IW-1:0] event_inc;
    logic            cnt_en, clear, snap, rd_req, rd_shadow;
    logic [1:0]      rd_addr;

    logic            ack_w, ack_s, rovf_w, rovf_s;
    logic [CW-1:0]   data_w, data_s;
    logic [NC-1:0]   ovf_w, ovf_s;

    typedef struct {
        logic [CW-1:0] dw;
        logic          ow;
        logic [CW-1:0] ds;
        logic          os;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    perf_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)) u_dut_w (
        .clock(clock), .reset(reset), .event_inc(event_inc), .cnt_en(cnt_en),
        .clear(clear), .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_ack(ack_w), .rd_data(data_w), .rd_ovf(rovf_w),
        .ovf(ovf_w)
    );

    perf_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)) u_dut_s (
        .clock(clock), .reset(reset), .event_inc(event_inc), .cnt_en(cnt_en),
        .clear(clear), .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_ack(ack_s), .rd_data(data_s), .rd_ovf(rovf_s),
        .ovf(ovf_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, pending read popped here.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ack_w", 64'(ack_w), 64'd1);
            chk("ack_s", 64'(ack_s), 64'd1);
            chk("data_w", 64'(data_w), 64'(e.dw));
            chk("ovf_rd_w", 64'(rovf_w), 64'(e.ow));
            chk("data_s", 64'(data_s), 64'(e.ds));
            chk("ovf_rd_s", 64'(rovf_s), 64'(e.os));
        end else begin
            chk("idle_ack_w", 64'(ack_w), 64'd0);
            chk("idle_ack_s", 64'(ack_s), 64'd0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_inc(input logic [IW-1:0] c0, input logic [IW-1:0] c1, input logic [IW-1:0] c2);
        event_inc = {c2, c1, c0};
    endtask

    task automatic rd(input logic [1:0] a, input logic sh,
                      input logic [CW-1:0] dw, input logic ow,
                      input logic [CW-1:0] ds, input logic os);
        rd_req    = 1'b1;
        rd_addr   = a;
        rd_shadow = sh;
        q.push_back('{dw, ow, ds, os});
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cnt_en = 1'b1; clear = 1'b0; snap = 1'b0; rd_req = 1'b1;
        rd_addr = 2'd0; rd_shadow = 1'b0;
        set_inc(3'd1, 3'd1, 3'd1);
        @(negedge clock);
        @(negedge clock);
        chk("rst_ack_w", 64'(ack_w), 64'd0);
        chk("rst_ack_s", 64'(ack_s), 64'd0);
        chk("rst_data_w", 64'(data_w), 64'd0);
        chk("rst_data_s", 64'(data_s), 64'd0);
        chk("rst_rovf_w", 64'(rovf_w), 64'd0);
        chk("rst_ovf_w", 64'(ovf_w), 64'd0);
        chk("rst_ovf_s", 64'(ovf_s), 64'd0);
        rd_req = 1'b0; cnt_en = 1'b0;
        set_inc(3'd0, 3'd0, 3'd0);
        @(negedge clock);
        reset = 1'b1;

        // ch0 counts 1 per cycle for 10 cycles
        cnt_en = 1'b1; set_inc(3'd1, 3'd0, 3'd0);
        run(10);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        rd(2'd0, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0);

        // ch2 inc 5 for 4 enabled cycles, then 3 disabled cycles
        cnt_en = 1'b1; set_inc(3'd0, 3'd0, 3'd5);
        run(4);
        cnt_en = 1'b0;
        run(3);
        set_inc(3'd0, 3'd0, 3'd0);
        rd(2'd0, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0);
        rd(2'd1, 1'b0, 8'd0,  1'b0, 8'd0,  1'b0);
        rd(2'd2, 1'b0, 8'd20, 1'b0, 8'd20, 1'b0);
        rd(2'd3, 1'b0, 8'd0,  1'b0, 8'd0,  1'b0);

        // ch1 preloaded to 254, then +3 twice: wrap vs saturate
        cnt_en = 1'b1; set_inc(3'd0, 3'd7, 3'd0);
        run(36);
        set_inc(3'd0, 3'd2, 3'd0);
        run(1);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        rd(2'd1, 1'b0, 8'd254, 1'b0, 8'd254, 1'b0);
        cnt_en = 1'b1; set_inc(3'd0, 3'd3, 3'd0);
        run(1);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        chk("ovf_vec_w", 64'(ovf_w), 64'd2);
        chk("ovf_vec_s", 64'(ovf_s), 64'd2);
        rd(2'd1, 1'b0, 8'd1, 1'b1, 8'd255, 1'b1);
        cnt_en = 1'b1; set_inc(3'd0, 3'd3, 3'd0);
        run(1);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        rd(2'd1, 1'b0, 8'd4, 1'b1, 8'd255, 1'b1);

        // clear beats a simultaneous enabled increment
        cnt_en = 1'b1; set_inc(3'd3, 3'd3, 3'd3); clear = 1'b1;
        run(1);
        clear = 1'b0; cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        chk("clr_ovf_w", 64'(ovf_w), 64'd0);
        chk("clr_ovf_s", 64'(ovf_s), 64'd0);
        rd(2'd1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        rd(2'd2, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

        // snapshot isolation: ch1 at 7, snap with a same-cycle increment
        cnt_en = 1'b1; set_inc(3'd0, 3'd7, 3'd0);
        run(1);
        snap = 1'b1; set_inc(3'd0, 3'd1, 3'd0);
        run(1);
        snap = 1'b0;
        run(5);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        rd(2'd1, 1'b1, 8'd7,  1'b0, 8'd7,  1'b0);
        rd(2'd1, 1'b0, 8'd13, 1'b0, 8'd13, 1'b0);
        snap = 1'b1;
        rd(2'd1, 1'b1, 8'd7,  1'b0, 8'd7,  1'b0);
        snap = 1'b0;
        rd(2'd1, 1'b1, 8'd13, 1'b0, 8'd13, 1'b0);
        cnt_en = 1'b1; set_inc(3'd0, 3'd2, 3'd0);
        run(1);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        snap = 1'b1; clear = 1'b1;
        rd(2'd1, 1'b0, 8'd15, 1'b0, 8'd15, 1'b0);
        snap = 1'b0; clear = 1'b0;
        rd(2'd1, 1'b1, 8'd15, 1'b0, 8'd15, 1'b0);
        rd(2'd1, 1'b0, 8'd0,  1'b0, 8'd0,  1'b0);

        // shadow keeps the overflow flag across a clear: 37*7 = 259
        cnt_en = 1'b1; set_inc(3'd0, 3'd7, 3'd0);
        run(37);
        cnt_en = 1'b0; set_inc(3'd0, 3'd0, 3'd0);
        snap = 1'b1;
        run(1);
        snap = 1'b0; clear = 1'b1;
        run(1);
        clear = 1'b0;
        rd(2'd1, 1'b1, 8'd3, 1'b1, 8'd255, 1'b1);
        rd(2'd1, 1'b0, 8'd0, 1'b0, 8'd0,   1'b0);

        // reset asserted right after a request is sampled: no ack follows
        rd_req = 1'b1; rd_addr = 2'd1; rd_shadow = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0; rd_req = 1'b0;
        @(negedge clock);
        chk("rstrd_ack_w", 64'(ack_w), 64'd0);
        chk("rstrd_ack_s", 64'(ack_s), 64'd0);
        chk("rstrd_data_w", 64'(data_w), 64'd0);
        chk("rstrd_data_s", 64'(data_s), 64'd0);
        @(negedge clock);
        chk("rstrd_ack2_w", 64'(ack_w), 64'd0);
        chk("rstrd_ack2_s", 64'(ack_s), 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
